// File: rtl/mem_arbiter_pkg.sv
// Shared widths, state encoding and owner encoding for the memory-port arbiter.
package mem_arbiter_pkg;

   localparam int DEF_LINE_W      = 256;
   localparam int DEF_ADDR_W      = 16;
   localparam int DEF_OFFSET_BITS = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT_I,
      ST_GRANT_D,
      ST_MEM_WAIT,
      ST_RESP,
      ST_COOL
   } arb_state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin pick between icache and dcache; on a tie the requester
// that did not own the previous grant wins.
module mem_arbiter_rr_pick
   import mem_arbiter_pkg::*;
(
   input  logic req_icache,
   input  logic req_dcache,
   input  logic last,
   output logic valid,
   output logic owner
);

   assign valid = req_icache | req_dcache;
   assign owner = (req_dcache && (!req_icache || last == OWN_I)) ? OWN_D : OWN_I;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory line port between icache and dcache: grant, latch,
// run the memory handshake, return the line with a one-cycle ready pulse.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int LINE_W      = DEF_LINE_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              petitionICacheArb,
   input  logic [ADDR_W-1:0] addrICacheArb,
   output logic              serviceReadyArbICache,
   output logic [LINE_W-1:0] dataMemICache,
   input  logic              petitionDCacheArb,
   input  logic              writeDCacheArb,
   input  logic [ADDR_W-1:0] addrDCacheArb,
   input  logic [LINE_W-1:0] dataDCacheArb,
   output logic              serviceReadyArbDCache,
   output logic [LINE_W-1:0] dataMemDCache,
   output logic              memReq,
   output logic              memWrite,
   output logic [ADDR_W-1:0] memAddr,
   output logic [LINE_W-1:0] memWData,
   input  logic              memAck,
   input  logic [LINE_W-1:0] memRData,
   output logic              arbBusy
);

   // state       | meaning
   // ST_IDLE     | sample petitions, pick a requester
   // ST_GRANT_I  | latch icache request
   // ST_GRANT_D  | latch dcache request
   // ST_MEM_WAIT | memReq held until memAck
   // ST_RESP     | owner's ready pulse
   // ST_COOL     | one dead cycle so the owner can drop its petition

   arb_state_t state;
   logic       owner;
   logic       last_grant;
   logic       pick_valid;
   logic       pick_owner;

   mem_arbiter_rr_pick u_pick (
      .req_icache (petitionICacheArb),
      .req_dcache (petitionDCacheArb),
      .last       (last_grant),
      .valid      (pick_valid),
      .owner      (pick_owner)
   );

   assign arbBusy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state                 <= ST_IDLE;
         owner                 <= OWN_I;
         last_grant            <= OWN_I;
         memReq                <= 1'b0;
         memWrite              <= 1'b0;
         memAddr               <= '0;
         memWData              <= '0;
         serviceReadyArbICache <= 1'b0;
         serviceReadyArbDCache <= 1'b0;
         dataMemICache         <= '0;
         dataMemDCache         <= '0;
      end else begin
         serviceReadyArbICache <= 1'b0;
         serviceReadyArbDCache <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_valid)
                  state <= (pick_owner == OWN_D) ? ST_GRANT_D : ST_GRANT_I;
            end
            ST_GRANT_I: begin
               owner      <= OWN_I;
               last_grant <= OWN_I;
               memWrite   <= 1'b0;
               memAddr    <= {addrICacheArb[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
               memWData   <= '0;
               memReq     <= 1'b1;
               state      <= ST_MEM_WAIT;
            end
            ST_GRANT_D: begin
               owner      <= OWN_D;
               last_grant <= OWN_D;
               memWrite   <= writeDCacheArb;
               memAddr    <= {addrDCacheArb[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
               memWData   <= dataDCacheArb;
               memReq     <= 1'b1;
               state      <= ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
               if (memAck) begin
                  memReq <= 1'b0;
                  if (!memWrite) begin
                     if (owner == OWN_D) dataMemDCache <= memRData;
                     else                dataMemICache <= memRData;
                  end
                  if (owner == OWN_D) serviceReadyArbDCache <= 1'b1;
                  else                serviceReadyArbICache <= 1'b1;
                  state <= ST_RESP;
               end
            end
            ST_RESP: state <= ST_COOL;
            ST_COOL: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of the memory-port arbiter against a small
// round-robin/memory model kept in the bench.
module tb_mem_arbiter;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   logic         clk = 1'b0;
   logic         reset;
   logic         petitionICacheArb;
   logic [15:0]  addrICacheArb;
   logic         serviceReadyArbICache;
   logic [255:0] dataMemICache;
   logic         petitionDCacheArb;
   logic         writeDCacheArb;
   logic [15:0]  addrDCacheArb;
   logic [255:0] dataDCacheArb;
   logic         serviceReadyArbDCache;
   logic [255:0] dataMemDCache;
   logic         memReq;
   logic         memWrite;
   logic [15:0]  memAddr;
   logic [255:0] memWData;
   logic         memAck;
   logic [255:0] memRData;
   logic         arbBusy;

   int n_cmp = 0;
   int n_err = 0;
   bit mon_on = 1'b0;

   logic         last_model;
   logic [255:0] exp_dmi, exp_dmd;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk                   (clk),
      .reset                 (reset),
      .petitionICacheArb     (petitionICacheArb),
      .addrICacheArb         (addrICacheArb),
      .serviceReadyArbICache (serviceReadyArbICache),
      .dataMemICache         (dataMemICache),
      .petitionDCacheArb     (petitionDCacheArb),
      .writeDCacheArb        (writeDCacheArb),
      .addrDCacheArb         (addrDCacheArb),
      .dataDCacheArb         (dataDCacheArb),
      .serviceReadyArbDCache (serviceReadyArbDCache),
      .dataMemDCache         (dataMemDCache),
      .memReq                (memReq),
      .memWrite              (memWrite),
      .memAddr               (memAddr),
      .memWData              (memWData),
      .memAck                (memAck),
      .memRData              (memRData),
      .arbBusy               (arbBusy)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk)
      if (mon_on) chk("ready_overlap", {255'd0, serviceReadyArbICache & serviceReadyArbDCache}, 256'd0);

   // Waits for memReq, checks the latched request, acks after `delay` cycles
   // and checks the ready pulse. Returns on the COOL-cycle negedge.
   task automatic serve(input int delay, input logic [255:0] rdata, input logic exp_owner,
                        input logic exp_write, input logic [15:0] exp_addr,
                        input logic [255:0] exp_wdata, input bit drop_i);
      int n = 0;
      while (!memReq && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", {255'd0, memReq}, 256'd1);
      if (!memReq) return;
      chk("mem_write", {255'd0, memWrite}, {255'd0, exp_write});
      chk("mem_addr", {240'd0, memAddr}, {240'd0, exp_addr});
      chk("mem_wdata", memWData, exp_wdata);
      if (drop_i) petitionICacheArb = 1'b0;
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         chk("req_held", {255'd0, memReq}, 256'd1);
         chk("addr_stable", {240'd0, memAddr}, {240'd0, exp_addr});
      end
      memAck   = 1'b1;
      memRData = rdata;
      @(negedge clk);
      memAck   = 1'b0;
      memRData = '0;
      chk("ready_i", {255'd0, serviceReadyArbICache}, {255'd0, exp_owner == OWN_I});
      chk("ready_d", {255'd0, serviceReadyArbDCache}, {255'd0, exp_owner == OWN_D});
      chk("req_drop", {255'd0, memReq}, 256'd0);
      if (!exp_write) begin
         if (exp_owner == OWN_I) exp_dmi = rdata;
         else                    exp_dmd = rdata;
      end
      chk("data_i", dataMemICache, exp_dmi);
      chk("data_d", dataMemDCache, exp_dmd);
      @(negedge clk);
      chk("ready_cool", {254'd0, serviceReadyArbICache, serviceReadyArbDCache}, 256'd0);
   endtask

   logic [255:0] pat_a5, pat_11, rnd_line, wd;
   logic [15:0]  ai, ad;
   logic         pi, pd, wr, own;
   int           r, pulses;

   initial begin
      pat_a5 = {32{8'hA5}};
      pat_11 = {32{8'h11}};
      reset = 1'b1;
      petitionICacheArb = 1'b0; addrICacheArb = '0;
      petitionDCacheArb = 1'b0; writeDCacheArb = 1'b0; addrDCacheArb = '0; dataDCacheArb = '0;
      memAck = 1'b0; memRData = '0;
      exp_dmi = '0; exp_dmd = '0; last_model = OWN_I;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      mon_on = 1'b1;
      @(negedge clk);
      chk("rst_busy", {255'd0, arbBusy}, 256'd0);
      chk("rst_req", {255'd0, memReq}, 256'd0);
      chk("rst_addr", {240'd0, memAddr}, 256'd0);
      chk("rst_ready", {254'd0, serviceReadyArbICache, serviceReadyArbDCache}, 256'd0);
      chk("rst_data_i", dataMemICache, 256'd0);

      // icache fill, ack two cycles after memReq
      petitionICacheArb = 1'b1; addrICacheArb = 16'h1237;
      @(negedge clk);
      chk("grant_busy", {255'd0, arbBusy}, 256'd1);
      chk("grant_noreq", {255'd0, memReq}, 256'd0);
      serve(2, pat_a5, OWN_I, 1'b0, 16'h1230, 256'd0, 1'b0);
      petitionICacheArb = 1'b0;
      repeat (2) @(negedge clk);

      // simultaneous requests alternate D, I, D, I after reset
      reset = 1'b1; @(negedge clk); reset = 1'b0;
      exp_dmi = '0; exp_dmd = '0;
      for (int k = 0; k < 2; k++) begin
         petitionICacheArb = 1'b1; addrICacheArb = 16'h2000 + 16'(k);
         petitionDCacheArb = 1'b1; addrDCacheArb = 16'h3005; writeDCacheArb = 1'b0;
         dataDCacheArb = '0;
         serve(1, {8{32'hD0D0_0000 + 32'(k)}}, OWN_D, 1'b0, 16'h3000, 256'd0, 1'b0);
         petitionDCacheArb = 1'b0;
         serve(0, {8{32'h1CAC_0000 + 32'(k)}}, OWN_I, 1'b0, 16'h2000, 256'd0, 1'b0);
         petitionICacheArb = 1'b0;
         @(negedge clk);
      end

      // dcache write-back leaves dataMemDCache alone
      petitionDCacheArb = 1'b1; writeDCacheArb = 1'b1; addrDCacheArb = 16'h00FF;
      dataDCacheArb = pat_11;
      serve(1, pat_a5, OWN_D, 1'b1, 16'h00F0, pat_11, 1'b0);
      chk("wb_data_hold", dataMemDCache, {8{32'hD0D0_0001}});
      petitionDCacheArb = 1'b0; writeDCacheArb = 1'b0; dataDCacheArb = '0;
      @(negedge clk);

      // icache flush while in MEM_WAIT: still completes, no grant during COOL
      petitionICacheArb = 1'b1; addrICacheArb = 16'h4444;
      serve(3, {8{32'h4444_4444}}, OWN_I, 1'b0, 16'h4440, 256'd0, 1'b1);
      petitionDCacheArb = 1'b1; addrDCacheArb = 16'h0019;
      @(negedge clk);
      chk("cool_no_grant", {255'd0, arbBusy}, 256'd0);
      serve(0, {8{32'h0019_0019}}, OWN_D, 1'b0, 16'h0010, 256'd0, 1'b0);
      petitionDCacheArb = 1'b0;
      @(negedge clk);

      // reset while waiting on memory, then a stray ack
      petitionICacheArb = 1'b1; addrICacheArb = 16'h5555;
      r = 0;
      while (!memReq && r < 20) begin @(negedge clk); r++; end
      chk("mw_req", {255'd0, memReq}, 256'd1);
      petitionICacheArb = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mwrst_req", {255'd0, memReq}, 256'd0);
      chk("mwrst_busy", {255'd0, arbBusy}, 256'd0);
      chk("mwrst_addr", {240'd0, memAddr}, 256'd0);
      chk("mwrst_write", {255'd0, memWrite}, 256'd0);
      chk("mwrst_data_i", dataMemICache, 256'd0);
      chk("mwrst_data_d", dataMemDCache, 256'd0);
      memAck = 1'b1; memRData = pat_a5;
      @(negedge clk);
      memAck = 1'b0; memRData = '0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         pulses += int'(serviceReadyArbICache) + int'(serviceReadyArbDCache);
         @(negedge clk);
      end
      chk("late_ack_pulses", 256'(pulses), 256'd0);
      chk("late_ack_busy", {255'd0, arbBusy}, 256'd0);
      chk("late_ack_data", dataMemICache, 256'd0);

      // back-to-back random traffic, immediate ack
      exp_dmi = '0; exp_dmd = '0; last_model = OWN_I;
      for (int it = 0; it < 1000; it++) begin
         r  = int'($urandom_range(1, 3));
         pi = r[0]; pd = r[1];
         ai = 16'($urandom()); ad = 16'($urandom());
         wr = 1'($urandom_range(0, 1));
         for (int k = 0; k < 8; k++) begin
            wd[k*32 +: 32]       = $urandom();
            rnd_line[k*32 +: 32] = $urandom();
         end
         petitionICacheArb = pi; addrICacheArb = ai;
         petitionDCacheArb = pd; addrDCacheArb = ad;
         writeDCacheArb = wr; dataDCacheArb = wd;
         own = (pi && pd) ? ~last_model : (pd ? OWN_D : OWN_I);
         last_model = own;
         if (own == OWN_D)
            serve(0, rnd_line, OWN_D, wr, {ad[15:4], 4'h0}, wd, 1'b0);
         else
            serve(0, rnd_line, OWN_I, 1'b0, {ai[15:4], 4'h0}, 256'd0, 1'b0);
      end
      petitionICacheArb = 1'b0; petitionDCacheArb = 1'b0;
      repeat (3) @(negedge clk);
      mon_on = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
